// File: rtl/tt_mux_sel_sequencer.sv
// Drives the project-mux reset/increment/enable wires to select a requested project address,
// skipping the counter reset when the target can be reached by incrementing alone.
module tt_mux_sel_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned RST_CYC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              sel_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned MaxCyc = (RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC;
  localparam int unsigned TW     = $clog2(MaxCyc) + 1;
  localparam logic [TW-1:0] PulseLd = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] RstLd   = TW'(RST_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDisable,
    StReset,
    StRstRel,
    StIncHi,
    StIncLo,
    StEnable
  } state_e;

  state_e            state_q;
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ena_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic              sel_valid_q;
  logic              rst_n_q;
  logic              inc_q;
  logic              ctrl_ena_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] diff;

  assign diff = addr_q - cur_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      addr_q      <= '0;
      ena_q       <= 1'b0;
      n_q         <= '0;
      cur_addr_q  <= '0;
      sel_valid_q <= 1'b0;
      rst_n_q     <= 1'b0;
      inc_q       <= 1'b0;
      ctrl_ena_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            ena_q      <= req_ena;
            ctrl_ena_q <= 1'b0;
            busy_q     <= 1'b1;
            timer_q    <= PulseLd;
            state_q    <= StDisable;
          end
        end
        StDisable: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (sel_valid_q && (addr_q >= cur_addr_q)) begin
            // Target reachable by counting up from the current selection.
            n_q <= diff;
            if (diff == '0) begin
              done_q     <= 1'b1;
              ctrl_ena_q <= ena_q;
              state_q    <= StEnable;
            end else begin
              inc_q   <= 1'b1;
              timer_q <= PulseLd;
              state_q <= StIncHi;
            end
          end else begin
            rst_n_q     <= 1'b0;
            cur_addr_q  <= '0;
            sel_valid_q <= 1'b0;
            n_q         <= addr_q;
            timer_q     <= RstLd;
            state_q     <= StReset;
          end
        end
        StReset: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            rst_n_q     <= 1'b1;
            sel_valid_q <= 1'b1;
            timer_q     <= PulseLd;
            state_q     <= StRstRel;
          end
        end
        StRstRel: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (n_q == '0) begin
            done_q     <= 1'b1;
            ctrl_ena_q <= ena_q;
            state_q    <= StEnable;
          end else begin
            inc_q   <= 1'b1;
            timer_q <= PulseLd;
            state_q <= StIncHi;
          end
        end
        StIncHi: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            inc_q      <= 1'b0;
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            timer_q    <= PulseLd;
            state_q    <= StIncLo;
          end
        end
        StIncLo: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            n_q <= n_q - ADDR_W'(1);
            if (n_q == ADDR_W'(1)) begin
              done_q     <= 1'b1;
              ctrl_ena_q <= ena_q;
              state_q    <= StEnable;
            end else begin
              inc_q   <= 1'b1;
              timer_q <= PulseLd;
              state_q <= StIncHi;
            end
          end
        end
        StEnable: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // busy_q is low exactly when the FSM sits in StIdle.
  assign req_ready      = ~busy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cur_addr       = cur_addr_q;
  assign sel_valid      = sel_valid_q;
  assign ctrl_sel_rst_n = rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ctrl_ena_q;

endmodule

// File: tb/tb_tt_mux_sel_sequencer.sv
// Directed bench for tt_mux_sel_sequencer: pulse-train shape, latency and selection tracking.
module tb_tt_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       req_ena;
  logic       busy;
  logic       done;
  logic [9:0] cur_addr;
  logic       sel_valid;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  int vec   = 0;
  int fails = 0;

  tt_mux_sel_sequencer #(
    .ADDR_W   (10),
    .PULSE_CYC(2),
    .RST_CYC  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_ena       (req_ena),
    .busy          (busy),
    .done          (done),
    .cur_addr      (cur_addr),
    .sel_valid     (sel_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_ena      (ctrl_ena)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_n"}, {31'd0, ctrl_sel_rst_n}, 0);
    chk({tag, "_inc"}, {31'd0, ctrl_sel_inc}, 0);
    chk({tag, "_ena"}, {31'd0, ctrl_ena}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_cur"}, {22'd0, cur_addr}, 0);
    chk({tag, "_selv"}, {31'd0, sel_valid}, 0);
  endtask

  // Issue one request and track the pulse train up to the done pulse.
  task automatic do_req(input string tag, input logic [9:0] a, input logic e, input int lat,
                        input int rlow, input int incs);
    int   waitc = 0;
    int   c = 0;
    int   rl = 0;
    int   ir = 0;
    int   ih = 0;
    int   viol = 0;
    logic prst, pinc;
    req_addr  = a;
    req_ena   = e;
    req_valid = 1'b1;
    while (!req_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    chk({tag, "_ena_off"}, {31'd0, ctrl_ena}, 0);
    prst = ctrl_sel_rst_n;
    pinc = ctrl_sel_inc;
    while (c < 200) begin
      tick();
      c++;
      if (!ctrl_sel_rst_n) rl++;
      if (ctrl_sel_inc && !pinc) ir++;
      if (ctrl_sel_inc) ih++;
      if ((ctrl_sel_rst_n !== prst || ctrl_sel_inc !== pinc) && ctrl_ena) viol++;
      prst = ctrl_sel_rst_n;
      pinc = ctrl_sel_inc;
      if (done) break;
    end
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_rstlow"}, rl, rlow);
    chk({tag, "_incs"}, ir, incs);
    chk({tag, "_inchigh"}, ih, 2 * incs);
    chk({tag, "_enaviol"}, viol, 0);
    chk({tag, "_ena"}, {31'd0, ctrl_ena}, {31'd0, e});
    chk({tag, "_cur"}, {22'd0, cur_addr}, {22'd0, a});
    chk({tag, "_selv"}, {31'd0, sel_valid}, 1);
    tick();
    chk({tag, "_done_clr"}, {31'd0, done}, 0);
    chk({tag, "_idle"}, {31'd0, busy}, 0);
    chk({tag, "_ena_hold"}, {31'd0, ctrl_ena}, {31'd0, e});
  endtask

  initial begin
    int w;
    int acc;
    int dn;
    int bad;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_ena   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    tick();
    chk("por_ready", {31'd0, req_ready}, 1);

    // Full path from reset, then incremental, then backwards (forces full path).
    do_req("a3", 10'd3, 1'b1, 20, 5, 3);
    do_req("a5", 10'd5, 1'b1, 10, 0, 2);
    do_req("a2", 10'd2, 1'b1, 16, 4, 2);

    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst2");
    #1 reset = 1'b0;
    tick();
    do_req("a0", 10'd0, 1'b0, 8, 5, 0);

    // Reset while incrementing toward 7.
    req_addr  = 10'd7;
    req_ena   = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    w = 0;
    while (!ctrl_sel_inc && w < 50) begin
      tick();
      w++;
    end
    chk("mid_inc_seen", {31'd0, ctrl_sel_inc}, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    #1 reset = 1'b0;
    tick();
    do_req("a1", 10'd1, 1'b1, 12, 5, 1);

    // Requester holds valid throughout; address changes after the first accept.
    req_addr  = 10'd4;
    req_ena   = 1'b1;
    req_valid = 1'b1;
    acc = 0;
    dn  = 0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (req_valid && req_ready) acc++;
      tick();
      if (acc == 1) req_addr = 10'd2;
      if (acc == 2) req_valid = 1'b0;
      if (done) begin
        dn++;
        if (req_ready) bad++;
      end
    end
    chk("hold_accepts", acc, 2);
    chk("hold_dones", dn, 2);
    chk("hold_ready_in_en", bad, 0);
    chk("hold_cur", {22'd0, cur_addr}, 2);
    chk("hold_ena", {31'd0, ctrl_ena}, 1);
    chk("hold_idle", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
